// File: rtl/sha256_msg_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_msg_ctrl
// Front-end for the SHA-256 compression core. Collects a byte-granular
// message as big-endian 32-bit words, applies FIPS 180-4 padding and the
// 64-bit bit-length trailer, hands 512-bit blocks plus the chained H value to
// the core one run at a time, and returns the final digest over valid/ready.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_data/s_valid  message word in (first byte in [31:24]) and its valid
//   s_ready         word accepted this cycle when s_valid is also high
//   s_last/s_bytes  final word marker and its valid byte count (0..4)
//   blk_H/blk_M     chaining value and message block to the core
//   blk_start       one-cycle pulse launching a core run
//   blk_Hout        core result; captured on the first blk_done in WAIT
//   blk_done        core output valid
//   digest          final hash, word a in [255:224]
//   digest_valid    digest available; held until digest_ready
//   digest_ready    consumer accepts the digest
//
// state | meaning
// IDLE  | reload IV, clear counters and block buffer
// LOAD  | accept message words into the block buffer
// ISSUE | pulse blk_start for one cycle
// WAIT  | core busy; capture H on blk_done and pick the next step
// PADX  | build the extra padding/length-only block
// OUT   | present digest until the consumer takes it
// ---------------------------------------------------------------------------
module sha256_msg_ctrl #(
  parameter int LEN_W = 61
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  input  logic [2:0]    s_bytes,
  output logic [255:0]  blk_H,
  output logic [511:0]  blk_M,
  output logic          blk_start,
  input  logic [255:0]  blk_Hout,
  input  logic          blk_done,
  output logic [255:0]  digest,
  output logic          digest_valid,
  input  logic          digest_ready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_PADX  = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic [2:0]             state_q, state_d;
  logic [255:0]           h_q, h_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [4:0]             idx_q, idx_d;
  // word 0 is the leftmost slice, byte 0 of each word is its MSB byte
  logic [0:15][0:3][7:0]  blk_m_q, blk_m_d;
  logic                   more_q, more_d;
  logic                   need_x_q, need_x_d;
  logic                   fin_q, fin_d;
  logic                   pad_pend_q, pad_pend_d;

  logic [2:0]             b_eff;
  logic [31:0]            keep_mask;
  logic [6:0]             off;
  logic [63:0]            len_bits;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    blk_m_d    = blk_m_q;
    more_d     = more_q;
    need_x_d   = need_x_q;
    fin_d      = fin_q;
    pad_pend_d = pad_pend_q;
    b_eff      = '0;
    keep_mask  = '0;
    off        = '0;
    len_bits   = '0;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_LOAD;
        h_d        = IV;
        cnt_d      = '0;
        idx_d      = '0;
        blk_m_d    = '0;
        more_d     = 1'b0;
        need_x_d   = 1'b0;
        fin_d      = 1'b0;
        pad_pend_d = 1'b0;
      end

      ST_LOAD: begin
        if (s_valid) begin
          idx_d = idx_q + 5'd1;
          if (!s_last) begin
            blk_m_d[idx_q[3:0]] = s_data;
            cnt_d = cnt_q + LEN_W'(4);
            if (idx_q[3:0] == 4'd15) begin
              state_d  = ST_ISSUE;
              more_d   = 1'b1;
              need_x_d = 1'b0;
              fin_d    = 1'b0;
            end
          end else begin
            b_eff = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
            case (b_eff)
              3'd0:    keep_mask = 32'h0000_0000;
              3'd1:    keep_mask = 32'hff00_0000;
              3'd2:    keep_mask = 32'hffff_0000;
              3'd3:    keep_mask = 32'hffff_ff00;
              default: keep_mask = 32'hffff_ffff;
            endcase
            blk_m_d[idx_q[3:0]] = s_data & keep_mask;
            cnt_d    = cnt_q + LEN_W'(b_eff);
            len_bits = 64'({cnt_d, 3'b000});
            // byte offset just past the data inside this block (0..64)
            off = {1'b0, idx_q[3:0], 2'b00} + {4'b0000, b_eff};
            if (off < 7'd64)
              blk_m_d[off[5:2]][off[1:0]] = 8'h80;
            if (off <= 7'd55) begin
              blk_m_d[14] = len_bits[63:32];
              blk_m_d[15] = len_bits[31:0];
              fin_d       = 1'b1;
              need_x_d    = 1'b0;
              pad_pend_d  = 1'b0;
            end else begin
              fin_d       = 1'b0;
              need_x_d    = 1'b1;
              // data filled the block exactly; the 0x80 moves to the extra block
              pad_pend_d  = (off == 7'd64);
            end
            more_d  = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: state_d = ST_WAIT;

      ST_WAIT: begin
        if (blk_done) begin
          h_d = blk_Hout;
          if (more_q) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            blk_m_d = '0;
            more_d  = 1'b0;
          end else if (need_x_q) begin
            state_d = ST_PADX;
          end else if (fin_q) begin
            state_d = ST_OUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_PADX: begin
        len_bits    = 64'({cnt_q, 3'b000});
        blk_m_d     = '0;
        blk_m_d[0]  = pad_pend_q ? 32'h8000_0000 : 32'h0000_0000;
        blk_m_d[14] = len_bits[63:32];
        blk_m_d[15] = len_bits[31:0];
        need_x_d    = 1'b0;
        pad_pend_d  = 1'b0;
        fin_d       = 1'b1;
        state_d     = ST_ISSUE;
      end

      ST_OUT: begin
        if (digest_ready)
          state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      h_q        <= IV;
      cnt_q      <= '0;
      idx_q      <= '0;
      blk_m_q    <= '0;
      more_q     <= 1'b0;
      need_x_q   <= 1'b0;
      fin_q      <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      blk_m_q    <= blk_m_d;
      more_q     <= more_d;
      need_x_q   <= need_x_d;
      fin_q      <= fin_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  assign s_ready      = (state_q == ST_LOAD);
  assign blk_start    = (state_q == ST_ISSUE);
  assign digest_valid = (state_q == ST_OUT);
  assign digest       = digest_valid ? h_q : '0;
  assign blk_H        = h_q;
  assign blk_M        = blk_m_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
module tb_sha256_msg_ctrl;

  typedef logic [7:0] bq_t[$];

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [2:0]    s_bytes = '0;
  logic [255:0]  blk_H;
  logic [511:0]  blk_M;
  logic          blk_start;
  logic [255:0]  blk_Hout = '0;
  logic          blk_done = 1'b0;
  logic [255:0]  digest;
  logic          digest_valid;
  logic          digest_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_msg_ctrl dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_bytes(s_bytes),
    .blk_H(blk_H), .blk_M(blk_M), .blk_start(blk_start),
    .blk_Hout(blk_Hout), .blk_done(blk_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready)
  );

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // core model: done pulse 65 cycles after blk_start, unaffected by rst
  int           core_cnt = 0;
  int           n_start = 0;
  logic [255:0] core_h = '0;
  logic [511:0] core_m = '0;
  logic         watch = 1'b0;
  logic         h_moved = 1'b0;
  logic [511:0] blocks[$];

  always @(negedge clk) begin
    blk_done = 1'b0;
    if (watch && !rst && blk_H !== core_h) h_moved = 1'b1;
    if (blk_start) begin
      core_h = blk_H;
      core_m = blk_M;
      core_cnt = 65;
      n_start++;
      blocks.push_back(blk_M);
      watch = 1'b1;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        blk_done = 1'b1;
        blk_Hout = sha_comp(core_h, core_m);
        watch = 1'b0;
      end
    end
    if (rst) watch = 1'b0;
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    @(negedge clk);
    s_data = d; s_last = last; s_bytes = nb; s_valid = 1'b1;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      check_val("s_ready_timeout", {511'b0, s_ready}, 512'd1);
      s_valid = 1'b0; s_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // unused low bytes of the tail word carry 0xFF to exercise masking
  task automatic send_bytes(input bq_t msg);
    int n = msg.size();
    int nfull = n / 4;
    int rem = n % 4;
    logic [31:0] w;
    if (n == 0) begin
      send_word(32'hffff_ffff, 1'b1, 3'd0);
      return;
    end
    for (int i = 0; i < nfull; i++) begin
      w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      if (rem == 0 && i == nfull - 1) send_word(w, 1'b1, 3'd4);
      else                             send_word(w, 1'b0, 3'd0);
    end
    if (rem != 0) begin
      w = 32'hffff_ffff;
      for (int j = 0; j < rem; j++) w[31 - 8*j -: 8] = msg[4*nfull + j];
      send_word(w, 1'b1, 3'(rem));
    end
  endtask

  task automatic get_digest(input string tag, input logic [255:0] exp, input int hold);
    int t = 0;
    while (!digest_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_valid"}, {511'b0, digest_valid}, 512'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_valid"}, {511'b0, digest_valid}, 512'd1);
      check_val({tag, "_hold_digest"}, {256'b0, digest}, {256'b0, exp});
      check_val({tag, "_hold_s_ready"}, {511'b0, s_ready}, 512'd0);
    end
    check_val({tag, "_digest"}, {256'b0, digest}, {256'b0, exp});
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_valid_drop"}, {511'b0, digest_valid}, 512'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int t;
    bq_t q;
    logic [511:0] eb1, eb2;

    repeat (3) @(negedge clk);
    check_val("rst_s_ready", {511'b0, s_ready}, 512'd0);
    check_val("rst_blk_start", {511'b0, blk_start}, 512'd0);
    check_val("rst_digest_valid", {511'b0, digest_valid}, 512'd0);
    check_val("rst_digest", {256'b0, digest}, 512'd0);
    check_val("rst_blk_H", {256'b0, blk_H}, {256'b0, IV});
    check_val("rst_blk_M", blk_M, 512'd0);
    rst = 1'b0;

    // empty message
    blocks.delete(); base = n_start;
    q = {};
    send_bytes(q);
    get_digest("empty", 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 0);
    check_val("empty_starts", 512'(n_start - base), 512'd1);
    check_val("empty_block", blocks[0], {32'h8000_0000, 480'h0});

    // "abc", digest held 20 cycles
    blocks.delete(); base = n_start;
    send_bytes(str2q("abc"));
    get_digest("abc", 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 20);
    check_val("abc_starts", 512'(n_start - base), 512'd1);
    check_val("abc_w0", {480'b0, blocks[0][511:480]}, 512'h6162_6380);
    check_val("abc_w15", {480'b0, blocks[0][31:0]}, 512'h0000_0018);

    // 56 bytes: padding spills into an extra block
    blocks.delete(); base = n_start;
    send_bytes(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"));
    get_digest("msg56", 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 0);
    check_val("msg56_starts", 512'(n_start - base), 512'd2);
    check_val("msg56_b0_w14", {480'b0, blocks[0][63:32]}, 512'h8000_0000);
    check_val("msg56_b1", blocks[1], 512'h1c0);

    // 55 bytes: 0x80 in the last byte before the length, single block
    blocks.delete(); base = n_start;
    q = {};
    eb1 = '0;
    for (int i = 0; i < 55; i++) begin
      q.push_back(8'(i));
      eb1[511 - 8*i -: 8] = 8'(i);
    end
    eb1[511 - 8*55 -: 8] = 8'h80;
    eb1[31:0] = 32'h0000_01b8;
    send_bytes(q);
    get_digest("msg55", sha_comp(IV, eb1), 0);
    check_val("msg55_starts", 512'(n_start - base), 512'd1);
    check_val("msg55_w13", {480'b0, blocks[0][95:64]}, 512'h3435_3680);
    check_val("msg55_block", blocks[0], eb1);

    // 64 bytes: last word fills the block, pad pending into the extra block
    blocks.delete(); base = n_start;
    q = {};
    eb1 = '0;
    for (int i = 0; i < 64; i++) begin
      q.push_back(8'(i + 16));
      eb1[511 - 8*i -: 8] = 8'(i + 16);
    end
    eb2 = {32'h8000_0000, 416'h0, 64'd512};
    send_bytes(q);
    get_digest("msg64", sha_comp(sha_comp(IV, eb1), eb2), 0);
    check_val("msg64_starts", 512'(n_start - base), 512'd2);
    check_val("msg64_b0", blocks[0], eb1);
    check_val("msg64_b1_w0", {480'b0, blocks[1][511:480]}, 512'h8000_0000);
    check_val("msg64_b1_w15", {480'b0, blocks[1][31:0]}, 512'h0000_0200);

    // s_bytes above 4 counts as 4
    blocks.delete(); base = n_start;
    eb1 = {32'h6162_6364, 32'h8000_0000, 384'h0, 64'h20};
    send_word(32'h6162_6364, 1'b1, 3'd7);
    get_digest("bytes7", sha_comp(IV, eb1), 0);
    check_val("bytes7_block", blocks[0], eb1);

    // reset while the core runs the first block of a longer message
    base = n_start;
    for (int i = 0; i < 16; i++) send_word(32'h0101_0101, 1'b0, 3'd0);
    t = 0;
    while (n_start == base && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_first_start", 512'(n_start - base), 512'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_s_ready", {511'b0, s_ready}, 512'd0);
    check_val("mid_rst_blk_start", {511'b0, blk_start}, 512'd0);
    check_val("mid_rst_digest_valid", {511'b0, digest_valid}, 512'd0);
    check_val("mid_rst_digest", {256'b0, digest}, 512'd0);
    check_val("mid_rst_blk_H", {256'b0, blk_H}, {256'b0, IV});
    check_val("mid_rst_blk_M", blk_M, 512'd0);
    rst = 1'b0;
    // the stale core done lands while waiting for the next message
    repeat (80) @(negedge clk);
    check_val("mid_idle_digest_valid", {511'b0, digest_valid}, 512'd0);
    blocks.delete(); base = n_start;
    send_bytes(str2q("abc"));
    get_digest("post_rst_abc", 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 0);
    check_val("post_rst_starts", 512'(n_start - base), 512'd1);

    check_val("blk_h_stable", {511'b0, h_moved}, 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
